host_frame_bridge: RTL and testbench

//  Host-side bridge between a byte stream (UART/SPI core) and the 34-bit command/response

---
 rtl/host_frame_bridge_if.sv | 29 ++
 rtl/host_frame_bridge.sv | 179 +++++++++++++++++
 tb/tb_host_frame_bridge.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/host_frame_bridge_if.sv
// Byte-stream and command/response FIFO signals of the host frame bridge.
// master is the bridge itself; slave is the host byte stream plus the FIFO side.
interface host_frame_bridge_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        frame_err;
    logic        fifo_write_full;
    logic [33:0] fifo_write_data;
    logic        fifo_write_inc;
    logic        fifo_read_empty;
    logic [33:0] fifo_read_data;
    logic        fifo_read_inc;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;

    modport master (
        input  in_byte, in_valid, fifo_write_full, fifo_read_empty, fifo_read_data, out_ready,
        output in_ready, frame_err, fifo_write_data, fifo_write_inc, fifo_read_inc,
               out_byte, out_valid
    );

    modport slave (
        output in_byte, in_valid, fifo_write_full, fifo_read_empty, fifo_read_data, out_ready,
        input  in_ready, frame_err, fifo_write_data, fifo_write_inc, fifo_read_inc,
               out_byte, out_valid
    );
endinterface

// File: rtl/host_frame_bridge.sv
// Packs 5-byte host frames into 34-bit command words and serialises response words back out;
// push lands 1 cycle after the last payload byte, in_ready drops while the command FIFO is full.
module host_frame_bridge #(
    parameter logic [5:0]  SYNC_MARK = 6'h2C,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned TO_W      = 11
) (
    input  logic                clk,
    input  logic                rst,
    host_frame_bridge_if.master bus
);

    typedef enum logic [2:0] {
        RX_HDR  = 3'b001,
        RX_DATA = 3'b010,
        RX_PUSH = 3'b100
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'b01,
        TX_SEND = 2'b10
    } tx_state_t;

    typedef struct packed {
        logic [1:0]  modifier;
        logic [31:0] payload;
    } cmd_word_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam bit              TO_EN   = (TIMEOUT != 0);

    // ---------------- ingress ----------------
    rx_state_t       rx_state;
    logic [1:0]      rx_mod;
    logic [31:0]     rx_payload;
    logic [1:0]      byte_cnt;
    logic [TO_W-1:0] idle_cnt;
    logic            in_ready_q;
    logic            frame_err_q;
    cmd_word_t       wr_data_q;
    logic            wr_inc_q;
    logic            rx_xfer;

    assign rx_xfer = bus.in_valid & in_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= RX_HDR;
            rx_mod      <= 2'b00;
            rx_payload  <= 32'h0;
            byte_cnt    <= 2'd0;
            idle_cnt    <= '0;
            in_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_data_q   <= '0;
            wr_inc_q    <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            wr_inc_q    <= 1'b0;
            case (rx_state)
                RX_HDR: begin
                    in_ready_q <= 1'b1;
                    idle_cnt   <= '0;
                    if (rx_xfer) begin
                        if (bus.in_byte[7:2] == SYNC_MARK) begin
                            rx_mod   <= bus.in_byte[1:0];
                            byte_cnt <= 2'd0;
                            rx_state <= RX_DATA;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_xfer) begin
                        rx_payload <= {rx_payload[23:0], bus.in_byte};
                        byte_cnt   <= byte_cnt + 2'd1;
                        idle_cnt   <= '0;
                        if (byte_cnt == 2'd3) begin
                            rx_state   <= RX_PUSH;
                            in_ready_q <= 1'b0;
                        end
                    end else if (TO_EN && idle_cnt == TO_LAST) begin
                        // host stalled mid-frame: drop the partial word and resync on a header
                        frame_err_q <= 1'b1;
                        idle_cnt    <= '0;
                        rx_state    <= RX_HDR;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                RX_PUSH: begin
                    in_ready_q <= 1'b0;
                    idle_cnt   <= '0;
                    if (!bus.fifo_write_full) begin
                        wr_data_q  <= '{modifier: rx_mod, payload: rx_payload};
                        wr_inc_q   <= 1'b1;
                        in_ready_q <= 1'b1;
                        rx_state   <= RX_HDR;
                    end
                end
                default: begin
                    in_ready_q <= 1'b0;
                    rx_state   <= RX_HDR;
                end
            endcase
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.frame_err       = frame_err_q;
    assign bus.fifo_write_data = wr_data_q;
    assign bus.fifo_write_inc  = wr_inc_q;

    // ---------------- egress ----------------
    tx_state_t  tx_state;
    cmd_word_t  tx_word;
    logic [2:0] tx_idx;
    logic [7:0] out_byte_q;
    logic       out_valid_q;
    logic       rd_inc_q;

    function automatic logic [7:0] tx_byte(input cmd_word_t w, input logic [2:0] i);
        case (i)
            3'd0:    tx_byte = {SYNC_MARK, w.modifier};
            3'd1:    tx_byte = w.payload[31:24];
            3'd2:    tx_byte = w.payload[23:16];
            3'd3:    tx_byte = w.payload[15:8];
            3'd4:    tx_byte = w.payload[7:0];
            default: tx_byte = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_word     <= '0;
            tx_idx      <= 3'd0;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            rd_inc_q    <= 1'b0;
        end else begin
            rd_inc_q <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (!bus.fifo_read_empty) begin
                        tx_word     <= bus.fifo_read_data;
                        rd_inc_q    <= 1'b1;
                        tx_idx      <= 3'd0;
                        out_byte_q  <= tx_byte(bus.fifo_read_data, 3'd0);
                        out_valid_q <= 1'b1;
                        tx_state    <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (bus.out_ready) begin
                        if (tx_idx == 3'd4) begin
                            out_valid_q <= 1'b0;
                            out_byte_q  <= 8'h00;
                            tx_state    <= TX_IDLE;
                        end else begin
                            tx_idx     <= tx_idx + 3'd1;
                            out_byte_q <= tx_byte(tx_word, tx_idx + 3'd1);
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    tx_state    <= TX_IDLE;
                end
            endcase
        end
    end

    assign bus.out_byte      = out_byte_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.fifo_read_inc = rd_inc_q;

endmodule

// File: tb/tb_host_frame_bridge.sv
// Directed bench for host_frame_bridge: framing, sync errors, timeout, backpressure, egress, reset.
module tb_host_frame_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    host_frame_bridge_if bus ();

    host_frame_bridge #(
        .SYNC_MARK (6'h2C),
        .TIMEOUT   (8),
        .TO_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    int         wr_cnt = 0;
    int         err_cnt = 0;
    int         rd_cnt = 0;
    logic [7:0] eg_q[$];
    logic       hold_en = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (hold_en && prev_hold)
            chk("egress_hold", {55'h0, bus.out_valid, bus.out_byte}, {55'h0, 1'b1, prev_byte});
        if (bus.out_valid && bus.out_ready) eg_q.push_back(bus.out_byte);
        if (bus.fifo_write_inc) wr_cnt <= wr_cnt + 1;
        if (bus.frame_err)      err_cnt <= err_cnt + 1;
        if (bus.fifo_read_inc)  rd_cnt <= rd_cnt + 1;
        prev_hold <= bus.out_valid && !bus.out_ready;
        prev_byte <= bus.out_byte;
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) chk("in_ready_wait", {63'h0, bus.in_ready}, 64'h1);
        tick();
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8]);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_push(input string tag, input logic [33:0] exp);
        chk({tag, "_early"}, {63'h0, bus.fifo_write_inc}, 64'h0);
        tick();
        chk({tag, "_inc"},   {63'h0, bus.fifo_write_inc}, 64'h1);
        chk({tag, "_data"},  {30'h0, bus.fifo_write_data}, {30'h0, exp});
        tick();
        chk({tag, "_single"}, {63'h0, bus.fifo_write_inc}, 64'h0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},  {63'h0, bus.in_ready}, 64'h0);
        chk({tag, "_frame_err"}, {63'h0, bus.frame_err}, 64'h0);
        chk({tag, "_wr_inc"},    {63'h0, bus.fifo_write_inc}, 64'h0);
        chk({tag, "_wr_data"},   {30'h0, bus.fifo_write_data}, 64'h0);
        chk({tag, "_rd_inc"},    {63'h0, bus.fifo_read_inc}, 64'h0);
        chk({tag, "_out_valid"}, {63'h0, bus.out_valid}, 64'h0);
        chk({tag, "_out_byte"},  {56'h0, bus.out_byte}, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, e0, r0, n;
        logic [7:0] exp5 [5];

        bus.in_byte         = 8'h00;
        bus.in_valid        = 1'b0;
        bus.fifo_write_full = 1'b0;
        bus.fifo_read_empty = 1'b1;
        bus.fifo_read_data  = 34'h0;
        bus.out_ready       = 1'b0;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // 1: clean frame
        w0 = wr_cnt; e0 = err_cnt;
        send_frame(40'hB1_1234_5678);
        expect_push("t1", 34'h1_1234_5678);
        chk("t1_push_count", 64'(wr_cnt - w0), 64'd1);
        chk("t1_no_err", 64'(err_cnt - e0), 64'd0);

        // 2: bad sync byte then a good frame
        w0 = wr_cnt; e0 = err_cnt;
        send_byte(8'h00);
        bus.in_valid = 1'b0;
        chk("t2_err_pulse", {63'h0, bus.frame_err}, 64'h1);
        tick();
        chk("t2_err_clear", {63'h0, bus.frame_err}, 64'h0);
        send_frame(40'hB0_DEAD_BEEF);
        expect_push("t2", 34'h0_DEAD_BEEF);
        chk("t2_err_count", 64'(err_cnt - e0), 64'd1);
        chk("t2_push_count", 64'(wr_cnt - w0), 64'd1);

        // 3: inter-byte timeout after 8 idle cycles
        w0 = wr_cnt; e0 = err_cnt;
        send_byte(8'hB3);
        send_byte(8'hAA);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.frame_err && n < 20) begin
            tick();
            n++;
        end
        chk("t3_timeout_cycles", 64'(n), 64'd8);
        tick();
        chk("t3_no_push", 64'(wr_cnt - w0), 64'd0);
        chk("t3_err_count", 64'(err_cnt - e0), 64'd1);
        send_frame(40'hB3_0102_0304);
        expect_push("t3", 34'h3_0102_0304);

        // 4: command FIFO full when frame completes
        w0 = wr_cnt;
        bus.fifo_write_full = 1'b1;
        send_frame(40'hB1_ABCD_EF01);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_in_ready", {63'h0, bus.in_ready}, 64'h0);
            chk("t4_hold_inc", {63'h0, bus.fifo_write_inc}, 64'h0);
        end
        bus.fifo_write_full = 1'b0;
        tick();
        chk("t4_inc", {63'h0, bus.fifo_write_inc}, 64'h1);
        chk("t4_data", {30'h0, bus.fifo_write_data}, {30'h0, 34'h1_ABCD_EF01});
        tick();
        chk("t4_single", {63'h0, bus.fifo_write_inc}, 64'h0);
        chk("t4_in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("t4_push_count", 64'(wr_cnt - w0), 64'd1);

        // 5: egress with out_ready toggling
        r0 = rd_cnt;
        eg_q.delete();
        hold_en = 1'b1;
        bus.out_ready = 1'b0;
        bus.fifo_read_data  = 34'h2_0000_0001;
        bus.fifo_read_empty = 1'b0;
        n = 0;
        while (eg_q.size() < 5 && n < 80) begin
            tick();
            if (bus.fifo_read_inc) bus.fifo_read_empty = 1'b1;
            bus.out_ready = ~bus.out_ready;
            n++;
        end
        chk("t5_byte_count", 64'(eg_q.size()), 64'd5);
        chk("t5_valid_drop", {63'h0, bus.out_valid}, 64'h0);
        bus.out_ready = 1'b0;
        hold_en = 1'b0;
        exp5 = '{8'hB2, 8'h00, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < 5; i++)
            if (i < eg_q.size()) chk($sformatf("t5_byte%0d", i), {56'h0, eg_q[i]}, {56'h0, exp5[i]});
        tick();
        chk("t5_pop_count", 64'(rd_cnt - r0), 64'd1);

        // 6: reset mid-ingress and mid-egress
        bus.fifo_read_data  = 34'h1_CAFE_F00D;
        bus.fifo_read_empty = 1'b0;
        n = 0;
        while (!bus.fifo_read_inc && n < 10) begin
            tick();
            n++;
        end
        chk("t6_pop", {63'h0, bus.fifo_read_inc}, 64'h1);
        bus.fifo_read_empty = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        send_byte(8'hB1);
        send_byte(8'h11);
        bus.in_valid = 1'b0;
        w0 = wr_cnt; e0 = err_cnt; r0 = rd_cnt;
        rst = 1'b1;
        tick();
        check_all_zero("t6_rst");
        rst = 1'b0;
        tick();
        tick();
        chk("t6_no_push", 64'(wr_cnt - w0), 64'd0);
        chk("t6_no_pop", 64'(rd_cnt - r0), 64'd0);
        chk("t6_no_err", 64'(err_cnt - e0), 64'd0);
        chk("t6_egress_idle", {63'h0, bus.out_valid}, 64'h0);
        send_frame(40'hB2_0123_4567);
        expect_push("t6", 34'h2_0123_4567);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
